vga_pixel_pipe: RTL and testbench
=================================

VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

Interface
REQ-001 SHALL expose: clk  input  1  system clock, 100 MHz; 4 clocks per 25 MHz pixel.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL expose: H_counter  input  12  horizontal clock count within a line, 0..3199, from the line counter.
REQ-004 SHALL expose: V_counter  input  10  line count within a frame, 0..520, from the frame counter.
REQ-005 SHALL expose: vram_addr  output  14  image memory address, {blk_y[6:0], blk_x[6:0]}.
REQ-006 SHALL expose: vram_rdata  input  3  {R,G,B} pixel word, valid 1 clock after vram_addr (synchronous ROM).
REQ-007 SHALL expose: VGA_R, VGA_G, VGA_B  output  1 each  pixel colour, forced 0 outside the visible area.
REQ-008 SHALL expose: VGA_HSYNC, VGA_VSYNC  output  1 each  sync outputs, active-low.
REQ-009 SHALL expose: frame_start  output  1  single-clock pulse marking the end of each frame.

Function
REQ-010 Horizontal decode (H_counter): visible 0..2559; front porch 2560..2623; sync 2624..3007; back porch 3008..3199.
REQ-011 Vertical decode (V_counter): visible 0..479; front porch 480..489; sync 490..491; back porch 492..520.
REQ-012 active = H visible AND V visible; hs_n = 0 iff H in sync; vs_n = 0 iff V in sync.
REQ-013 Image is 128x96, each image pixel shown as a 5x5 block of screen pixels (640x480).
REQ-014 Horizontal sub-counter sub_x (0..4) SHALL advance when H_counter<2560 and H_counter[1:0]==3.
REQ-015 On sub_x wrap 4->0, blk_x (0..127) SHALL increment.
REQ-016 When H_counter==3199, sub_x and blk_x SHALL clear to 0.
REQ-017 When H_counter==3199 and V_counter<480, sub_y (0..4) SHALL advance; on wrap 4->0, blk_y (0..95) SHALL increment.
REQ-018 When H_counter==3199 and V_counter==520, sub_y and blk_y SHALL clear to 0; this takes priority over REQ-017.
REQ-019 blk_x SHALL NOT exceed 127 and blk_y SHALL NOT exceed 95; reaching either bound without a clear is an assertion failure.
REQ-020 Stage 1 (1 clock after counters): vram_addr, active_d1, hs_d1, vs_d1 SHALL be registered.
REQ-021 Stage 2 (2 clocks after counters): outputs SHALL be registered as follows.
- VGA_R/G/B = active_d2 ? vram_rdata : 3'b000.
- VGA_HSYNC = hs_d2; VGA_VSYNC = vs_d2.
REQ-022 Total latency from counter value to pins SHALL be exactly 2 clocks, identical for colour and both syncs.
REQ-023 frame_start SHALL be 1 for exactly one clock, the clock after H_counter==3199 and V_counter==520.
REQ-024 Out-of-range counter inputs (H>3199, V>520) SHALL decode as blanked, sync inactive, with no counter advance.

Reset
REQ-025 While reset==0: all registers clear asynchronously.
- vram_addr=0; sub/blk counters=0; VGA_R/G/B=0; frame_start=0.
- VGA_HSYNC=1 and VGA_VSYNC=1 (inactive); pipeline valid/active flags=0.
REQ-026 Reset deassertion mid-frame SHALL resume with blk counters at 0; the first correct image starts after the next frame_start.

Structure
REQ-027 Shared package vga_timing_pkg SHALL hold:
- H/V visible, porch and sync boundary constants; H_TOTAL=3200, V_TOTAL=521.
- BLOCK_SIZE=5, IMG_W=128, IMG_H=96, ADDR_W=14.
REQ-028 One sub-module vga_block_counter (mod-5 prescaler + block counter; inputs: advance, clear; outputs: sub, blk) SHALL be instantiated twice, once horizontal and once vertical.

Verification
REQ-029 Assert reset=0 -> HSYNC=VSYNC=1, RGB=0, vram_addr=0, frame_start=0; release reset, then drive H=0,V=0 -> after 2 clocks RGB equals vram_rdata at address 0.
REQ-030 Sweep H 0..3199 on V=0 -> vram_addr steps every 20 clocks, reaches 127 at H=2540..2559, and returns to 0 after H=3199.
REQ-031 H=2624 -> VGA_HSYNC falls 2 clocks later; H=3008 -> VGA_HSYNC rises 2 clocks later; V=490..491 -> VGA_VSYNC low for 2 lines.
REQ-032 Full frame -> vram_addr row field increments every 5 lines, last address 12287 ({95,127}); frame_start pulses once, 1 clock after H=3199,V=520.
REQ-033 vram_rdata=3'b111 constant -> RGB=0 for H>=2560 or V>=480 (e.g. H=2600,V=10 and H=100,V=485).
REQ-034 Assert reset for 3 clocks at H=1000,V=200 -> outputs return to reset values immediately; after release, vram_addr=0 until the next visible region following frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing boundaries and image geometry for the 640x480 block-scaled pixel pipe.
package vga_timing_pkg;

    // Horizontal boundaries in 100 MHz clocks (4 clocks per pixel)
    localparam logic [11:0] H_VIS_END    = 12'd2560;  // first front-porch clock
    localparam logic [11:0] H_SYNC_START = 12'd2624;  // first sync clock
    localparam logic [11:0] H_SYNC_END   = 12'd3008;  // first back-porch clock
    localparam int          H_TOTAL      = 3200;
    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);

    // Vertical boundaries in lines
    localparam logic [9:0]  V_VIS_END    = 10'd480;   // first front-porch line
    localparam logic [9:0]  V_SYNC_START = 10'd490;   // first sync line
    localparam logic [9:0]  V_SYNC_END   = 10'd492;   // first back-porch line
    localparam int          V_TOTAL      = 521;
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);

    // Image geometry: 128x96 image, each pixel replicated as a 5x5 screen block
    localparam logic [2:0]  BLOCK_SIZE   = 3'd5;
    localparam int          IMG_W        = 128;
    localparam int          IMG_H        = 96;
    localparam int          BLK_W        = 7;
    localparam int          ADDR_W       = 14;

endpackage

// File: rtl/vga_block_counter.sv
// Mod-5 prescaler feeding a block counter that holds at its top value
// until cleared; used once per screen axis.
module vga_block_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX_BLK = IMG_W - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             clear,
    output logic [2:0]       sub,
    output logic [BLK_W-1:0] blk
);

    localparam logic [BLK_W-1:0] BLK_TOP = BLK_W'(MAX_BLK);
    localparam logic [2:0]       SUB_TOP = BLOCK_SIZE - 3'd1;

    // Clear wins over advance; the last block is held through blanking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub <= '0;
            blk <= '0;
        end else if (clear) begin
            sub <= '0;
            blk <= '0;
        end else if (advance) begin
            if (sub == SUB_TOP) begin
                sub <= '0;
                if (blk != BLK_TOP) blk <= blk + 1'b1;
            end else begin
                sub <= sub + 3'd1;
            end
        end
    end

    blk_in_range: assert property (@(posedge clk) disable iff (!reset) blk <= BLK_TOP);

endmodule

// File: rtl/vga_pixel_pipe.sv
// Two-stage VGA pixel pipe: decodes external H/V counters, walks a 128x96
// image at 5x magnification, and drives colour and syncs with equal latency.
module vga_pixel_pipe
    import vga_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       H_counter,
    input  logic [9:0]        V_counter,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [2:0]        vram_rdata,
    output logic              VGA_R,
    output logic              VGA_G,
    output logic              VGA_B,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC,
    output logic              frame_start
);

    logic             in_range, active, hs, vs;
    logic             line_end, frame_end, synced;
    logic             adv_x, clr_x, adv_y, clr_y;
    logic [2:0]       sub_x, sub_y;
    logic [BLK_W-1:0] blk_x, blk_y;
    logic             active_d1, active_d2;
    logic             hs_n_d1, vs_n_d1;

    // Out-of-range counters decode as fully idle: blanked, no sync, no advance
    assign in_range  = (H_counter <= H_LAST) && (V_counter <= V_LAST);
    assign active    = (H_counter < H_VIS_END) && (V_counter < V_VIS_END);
    assign hs        = in_range && (H_counter >= H_SYNC_START) && (H_counter < H_SYNC_END);
    assign vs        = in_range && (V_counter >= V_SYNC_START) && (V_counter < V_SYNC_END);
    assign line_end  = in_range && (H_counter == H_LAST);
    assign frame_end = line_end && (V_counter == V_LAST);

    // Counters stay parked at 0 after reset until a frame boundary is seen,
    // so a mid-frame release never produces a shifted image.
    assign adv_x = synced && in_range && (H_counter < H_VIS_END) && (H_counter[1:0] == 2'b11);
    assign clr_x = line_end;
    assign adv_y = synced && line_end && (V_counter < V_VIS_END);
    assign clr_y = frame_end;

    // Track whether the block counters are aligned to a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         synced <= 1'b0;
        else if (frame_end) synced <= 1'b1;
    end

    vga_block_counter #(.MAX_BLK(IMG_W - 1)) u_cnt_x (
        .clk     (clk),
        .reset   (reset),
        .advance (adv_x),
        .clear   (clr_x),
        .sub     (sub_x),
        .blk     (blk_x)
    );

    vga_block_counter #(.MAX_BLK(IMG_H - 1)) u_cnt_y (
        .clk     (clk),
        .reset   (reset),
        .advance (adv_y),
        .clear   (clr_y),
        .sub     (sub_y),
        .blk     (blk_y)
    );

    // Stage 1: address to the image ROM plus the matching decode flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vram_addr   <= '0;
            active_d1   <= 1'b0;
            hs_n_d1     <= 1'b1;
            vs_n_d1     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vram_addr   <= {blk_y, blk_x};
            active_d1   <= active;
            hs_n_d1     <= ~hs;
            vs_n_d1     <= ~vs;
            frame_start <= frame_end;
        end
    end

    // Stage 2: flags delayed to line up with the ROM's registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_d2 <= 1'b0;
            VGA_HSYNC <= 1'b1;
            VGA_VSYNC <= 1'b1;
        end else begin
            active_d2 <= active_d1;
            VGA_HSYNC <= hs_n_d1;
            VGA_VSYNC <= vs_n_d1;
        end
    end

    // The ROM output register is the colour's second stage; only gating remains
    assign {VGA_R, VGA_G, VGA_B} = active_d2 ? vram_rdata : 3'b000;

    sub_in_range: assert property (@(posedge clk) disable iff (!reset)
        (sub_x < BLOCK_SIZE) && (sub_y < BLOCK_SIZE));

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe with a synchronous image ROM model.
module tb_vga_pixel_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] H_counter;
    logic [9:0]  V_counter;
    logic [13:0] vram_addr;
    logic [2:0]  vram_rdata;
    logic        VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, frame_start;
    logic        rom_const = 1'b0;

    always #5 clk = ~clk;

    vga_pixel_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .H_counter   (H_counter),
        .V_counter   (V_counter),
        .vram_addr   (vram_addr),
        .vram_rdata  (vram_rdata),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HSYNC   (VGA_HSYNC),
        .VGA_VSYNC   (VGA_VSYNC),
        .frame_start (frame_start)
    );

    function automatic logic [2:0] rom_f(input logic [13:0] a);
        return a[2:0] ^ a[9:7] ^ 3'b101;
    endfunction

    // Synchronous ROM: data valid one clock after the address
    always @(posedge clk) vram_rdata <= rom_const ? 3'b111 : rom_f(vram_addr);

    typedef struct {
        logic [13:0] addr;
        logic        fs;
        logic [2:0]  rgb;
        logic        hs_n;
        logic        vs_n;
        int          h;
        int          v;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: advances counted since the last clear, scaled to blocks
    int   m_hcnt, m_vcnt;
    bit   m_synced;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " addr"},  32'(vram_addr), 32'd0);
        chk({tag, " hsync"}, 32'(VGA_HSYNC), 32'd1);
        chk({tag, " vsync"}, 32'(VGA_VSYNC), 32'd1);
        chk({tag, " rgb"},   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        chk({tag, " fs"},    32'(frame_start), 32'd0);
    endtask

    task automatic model_reset();
        m_hcnt   = 0;
        m_vcnt   = 0;
        m_synced = 1'b0;
        q1.delete();
        q2.delete();
    endtask

    // Drive one clock of counters, push expectations, check what has matured
    task automatic drive(input int h, input int v);
        exp_t e;
        bit   in_rng, le, fe;
        int   x, y;
        @(negedge clk);
        H_counter = 12'(h);
        V_counter = 10'(v);
        in_rng = (h <= 3199) && (v <= 520);
        x = m_hcnt / 5; if (x > 127) x = 127;
        y = m_vcnt / 5; if (y > 95)  y = 95;
        e.addr = 14'(y * 128 + x);
        le     = in_rng && (h == 3199);
        fe     = le && (v == 520);
        e.fs   = fe;
        e.rgb  = (h < 2560 && v < 480) ? (rom_const ? 3'b111 : rom_f(e.addr)) : 3'b000;
        e.hs_n = !(in_rng && h >= 2624 && h <= 3007);
        e.vs_n = !(in_rng && v >= 490 && v <= 491);
        e.h    = h;
        e.v    = v;
        if (le) m_hcnt = 0;
        else if (m_synced && in_rng && h < 2560 && (h % 4) == 3) m_hcnt++;
        if (fe) begin
            m_vcnt   = 0;
            m_synced = 1'b1;
        end else if (le && m_synced && v < 480) begin
            m_vcnt++;
        end
        q1.push_back(e);
        q2.push_back(e);
        @(posedge clk);
        #1;
        e = q1.pop_front();
        chk($sformatf("addr h=%0d v=%0d", e.h, e.v), 32'(vram_addr), 32'(e.addr));
        chk($sformatf("frame_start h=%0d v=%0d", e.h, e.v), 32'(frame_start), 32'(e.fs));
        if (q2.size() == 2) begin
            e = q2.pop_front();
            chk($sformatf("rgb h=%0d v=%0d", e.h, e.v), 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
            chk($sformatf("hsync h=%0d v=%0d", e.h, e.v), 32'(VGA_HSYNC), 32'(e.hs_n));
            chk($sformatf("vsync h=%0d v=%0d", e.h, e.v), 32'(VGA_VSYNC), 32'(e.vs_n));
        end
    endtask

    initial begin
        int pat4 [4] = '{0, 2600, 2700, 3199};
        int pat3 [3] = '{0, 2600, 3199};

        // Power-on reset
        reset     = 1'b0;
        H_counter = '0;
        V_counter = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        reset = 1'b1;

        // First pixel straight after release reads address 0
        repeat (3) drive(0, 0);

        // Frame boundary aligns the counters, then one full line on V=0
        drive(3199, 520);
        for (int h = 0; h < 3200; h++) drive(h, 0);

        // Rest of the frame: sparse samples per line, full sweep of the last visible line
        for (int v = 1; v <= 520; v++) begin
            if (v == 479) begin
                for (int h = 0; h < 3200; h++) drive(h, v);
            end else begin
                foreach (pat4[i]) drive(pat4[i], v);
            end
        end
        for (int h = 0; h < 100; h++) drive(h, 0);

        // Out-of-range counters: blanked, no sync, no advance
        drive(3, 600);
        drive(3300, 10);
        drive(2700, 600);
        drive(3300, 491);
        drive(100, 0);

        // White image: colour must still be gated outside the visible area
        drive(3300, 600);
        rom_const = 1'b1;
        drive(2600, 10);
        drive(100, 485);
        drive(100, 10);
        drive(2559, 479);
        drive(2560, 479);
        drive(3300, 600);
        rom_const = 1'b0;

        // Mid-frame reset: outputs clear at once, image parked until next frame
        drive(1000, 200);
        drive(1000, 200);
        reset = 1'b0;
        #1;
        chk_reset("rst_async");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst_hold");
        reset = 1'b1;
        for (int h = 1001; h <= 1400; h++) drive(h, 200);
        drive(3199, 200);
        for (int v = 201; v <= 520; v++) begin
            foreach (pat3[i]) drive(pat3[i], v);
        end
        for (int h = 0; h < 200; h++) drive(h, 0);
        drive(3300, 600);
        drive(3300, 600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
